// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and the decode stage.
// Holds the MIPS funct codes understood by the ALU slice, the sequencer
// state enum and a helper that tells whether a funct code subtracts.
package alu_serial_seq_pkg;

  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // SUB and SLT both compute A + ~B + 1.
  function automatic logic is_sub(input logic [FUNCT_W-1:0] funct);
    return (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_seq_alu.sv
// ALU: the team's 1-bit ALU slice.
// Ports:
//   dataA, dataB  operand bits
//   carryIn       carry into this bit
//   Signal        MIPS funct code (binvert is derived from it)
//   dataOut       result bit: a&b, a|b, or sum (ADD/SUB/SLT); 0 otherwise
//   carryOut      full-adder carry out; 0 for unsupported codes
module ALU
  import alu_serial_seq_pkg::*;
(
  input  logic               dataA,
  input  logic               dataB,
  input  logic               carryIn,
  input  logic [FUNCT_W-1:0] Signal,
  output logic               dataOut,
  output logic               carryOut
);

  logic binvert;
  logic b_eff;
  logic sum;
  logic cout;

  assign binvert = is_sub(Signal);
  assign b_eff   = dataB ^ binvert;
  assign sum     = dataA ^ b_eff ^ carryIn;
  assign cout    = (dataA & b_eff) | (dataA & carryIn) | (b_eff & carryIn);

  // SLT passes the sum through; the sequencer turns the MSB into the flag.
  always_comb begin
    dataOut  = 1'b0;
    carryOut = 1'b0;
    case (Signal)
      FUNCT_AND: begin
        dataOut  = dataA & dataB;
        carryOut = cout;
      end
      FUNCT_OR: begin
        dataOut  = dataA | dataB;
        carryOut = cout;
      end
      FUNCT_ADD, FUNCT_SUB, FUNCT_SLT: begin
        dataOut  = sum;
        carryOut = cout;
      end
      default: begin
        dataOut  = 1'b0;
        carryOut = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer.
// Latches a WIDTH-bit operand pair and a funct code, then feeds one bit per
// cycle (LSB first) through a single 1-bit ALU slice, chaining the carry
// through a register, and returns the full-width result with a done pulse.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, accepted only while ready=1
//   ready        high while idle and able to accept
//   dataA, dataB operands, latched on accept
//   Signal       funct code, latched on accept
//   result       final result, held until the next operation completes
//   done         one-cycle pulse, result valid
//   overflow     signed ADD/SUB overflow (only with ALU_SERIAL_OVF_EN)
// Optional feature macro: ALU_SERIAL_OVF_EN adds the overflow port/flop.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               ready,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [FUNCT_W-1:0] Signal,
  output logic [WIDTH-1:0]   result,
  output logic               done
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic               overflow
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     opa_q;
  logic [WIDTH-1:0]     opb_q;
  logic [FUNCT_W-1:0]   func_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     sr_q;
  logic                 carry_q;
  logic                 c_in_msb_q;
  logic                 c_out_msb_q;
  logic                 ready_q;
  logic                 done_q;
  logic [WIDTH-1:0]     result_q;

  logic                 slice_out;
  logic                 slice_cout;
  logic                 accept;
  logic                 msb_ovf;
  logic [WIDTH-1:0]     result_d;

  // Single bit slice; operands are shifted right so bit 0 is always current.
  ALU u_alu (
    .dataA    (opa_q[0]),
    .dataB    (opb_q[0]),
    .carryIn  (carry_q),
    .Signal   (func_q),
    .dataOut  (slice_out),
    .carryOut (slice_cout)
  );

  assign accept  = start & ready_q;
  assign msb_ovf = c_in_msb_q ^ c_out_msb_q;

  // SLT: sign of the difference corrected by the overflow term.
  always_comb begin
    result_d = sr_q;
    if (func_q == FUNCT_SLT) begin
      result_d = {{(WIDTH-1){1'b0}}, sr_q[WIDTH-1] ^ msb_ovf};
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      func_q      <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      carry_q     <= 1'b0;
      c_in_msb_q  <= 1'b0;
      c_out_msb_q <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            opa_q   <= dataA;
            opb_q   <= dataB;
            func_q  <= Signal;
            cnt_q   <= '0;
            sr_q    <= '0;
            carry_q <= is_sub(Signal);
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end else begin
            // ready re-arms one cycle after the done pulse
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          sr_q    <= {slice_out, sr_q[WIDTH-1:1]};
          opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
          opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
          carry_q <= slice_cout;
          if (cnt_q == LAST_BIT) begin
            c_in_msb_q  <= carry_q;
            c_out_msb_q <= slice_cout;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          ready_q  <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  logic overflow_q;

  // Overflow is reported for ADD/SUB only and held alongside result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      overflow_q <= ((func_q == FUNCT_ADD) || (func_q == FUNCT_SUB)) ? msb_ovf : 1'b0;
    end
  end

  assign overflow = overflow_q;
`endif

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed cases, randomized
// operations against an arithmetic reference model, start-while-busy and
// reset-mid-run scenarios. Overflow checks are compiled in with
// ALU_SERIAL_OVF_EN.
module tb_alu_serial_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TMO   = 200;

  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] result;
  logic             done;
`ifdef ALU_SERIAL_OVF_EN
  logic             overflow;
`endif

  int vectors;
  int miscompares;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ready  (ready),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .result (result),
    .done   (done)
`ifdef ALU_SERIAL_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the whole word.
  function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [5:0] f);
    case (f)
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_SLT:   return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic [5:0] f);
    logic [WIDTH-1:0] r;
    if (f == F_ADD) begin
      r = a + b;
      return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    if (f == F_SUB) begin
      r = a - b;
      return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return 1'b0;
  endfunction

  // Issue one operation and observe its completion (no checking here).
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [5:0] f,
                       output logic [WIDTH-1:0] res, output int lat,
                       output logic rdy_acc, output logic rdy_done,
                       output logic rdy_after, output logic ovf);
    @(negedge clk);
    dataA = a; dataB = b; Signal = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rdy_acc = ready;
    lat = 0;
    rdy_done = 1'bx;
    ovf = 1'b0;
    res = 'x;
    for (int i = 1; i <= int'(TMO); i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        rdy_done = ready;
        res = result;
`ifdef ALU_SERIAL_OVF_EN
        ovf = overflow;
`endif
        break;
      end
    end
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dataA = '0; dataB = '0; Signal = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", ready); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++;
    if (result !== '0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", result); end
`ifdef ALU_SERIAL_OVF_EN
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [5:0] f);
    logic [WIDTH-1:0] res;
    int lat;
    logic ra, rd, rf, ovf;
    do_op(a, b, f, res, lat, ra, rd, rf, ovf);
    vectors++;
    if (res !== ref_result(a, b, f)) begin
      miscompares++;
      $display("FAIL %s_result a=%h b=%h f=%b got=%h exp=%h", name, a, b, f, res, ref_result(a, b, f));
    end
    vectors++;
    if (lat != int'(WIDTH) + 1) begin
      miscompares++;
      $display("FAIL %s_done_latency got=%0d exp=%0d", name, lat, WIDTH + 1);
    end
    vectors++;
    if ({ra, rd, rf} !== 3'b001) begin
      miscompares++;
      $display("FAIL %s_ready_timing got(acc,done,after)=%b%b%b exp=001", name, ra, rd, rf);
    end
`ifdef ALU_SERIAL_OVF_EN
    vectors++;
    if (ovf !== ref_ovf(a, b, f)) begin
      miscompares++;
      $display("FAIL %s_overflow got=%b exp=%b", name, ovf, ref_ovf(a, b, f));
    end
`endif
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] res;
    int lat;
    logic ra, rd, rf, ovf;
    check_op("add", 32'd5, 32'd7, F_ADD);
    check_op("sub", 32'd3, 32'd5, F_SUB);
    check_op("slt_neg", 32'hFFFF_FFFF, 32'd1, F_SLT);
    check_op("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, F_SLT);
    check_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, F_AND);
    check_op("or", 32'hF0F0_F0F0, 32'hFF00_FF00, F_OR);
    check_op("unsupported", 32'hDEAD_BEEF, 32'h1234_5678, 6'b000000);
    check_op("add_ovf", 32'h7FFF_FFFF, 32'd1, F_ADD);
    // Absolute values from the worked examples, independent of the model.
    do_op(32'd3, 32'd5, F_SUB, res, lat, ra, rd, rf, ovf);
    vectors++;
    if (res !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sub_const got=%h exp=fffffffe", res); end
    do_op(32'h7FFF_FFFF, 32'h8000_0000, F_SLT, res, lat, ra, rd, rf, ovf);
    vectors++;
    if (res !== 32'd0) begin miscompares++; $display("FAIL slt_ovf_const got=%h exp=0", res); end
    do_op(32'hF0F0_F0F0, 32'hFF00_FF00, F_AND, res, lat, ra, rd, rf, ovf);
    vectors++;
    if (res !== 32'hF000_F000) begin miscompares++; $display("FAIL and_const got=%h exp=f000f000", res); end
  endtask

  task automatic test_random();
    logic [5:0] codes [5];
    logic [WIDTH-1:0] a, b;
    logic [5:0] f;
    codes[0] = F_AND; codes[1] = F_OR; codes[2] = F_ADD; codes[3] = F_SUB; codes[4] = F_SLT;
    for (int n = 0; n < 60; n++) begin
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) b = a;                // equal operands
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;    // most-negative
      if ($urandom_range(0, 9) == 0) f = 6'($urandom_range(0, 63));
      else f = codes[$urandom_range(0, 4)];
      check_op("random", a, b, f);
    end
  endtask

  task automatic test_start_during_run();
    int lat;
    int extra;
    logic [WIDTH-1:0] res;
    @(negedge clk);
    dataA = 32'd5; dataB = 32'd7; Signal = F_ADD; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    dataA = $urandom(); dataB = $urandom(); Signal = F_OR; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    res = 'x;
    for (int i = 7; i <= int'(TMO); i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; res = result; break; end
    end
    vectors++;
    if (res !== 32'd12) begin miscompares++; $display("FAIL busy_start_result got=%h exp=0000000c", res); end
    vectors++;
    if (lat != int'(WIDTH) + 1) begin miscompares++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, WIDTH + 1); end
    extra = 0;
    for (int i = 0; i < int'(WIDTH) + 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL busy_start_queued got=%0d extra done pulses exp=0", extra); end
    vectors++;
    if (result !== 32'd12) begin miscompares++; $display("FAIL busy_start_held got=%h exp=0000000c", result); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    dataA = 32'h1111_1111; dataB = 32'h2222_2222; Signal = F_ADD; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready, done} !== 2'b10) begin miscompares++; $display("FAIL midrst_flags got(ready,done)=%b%b exp=10", ready, done); end
    vectors++;
    if (result !== '0) begin miscompares++; $display("FAIL midrst_result got=%h exp=0", result); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < int'(WIDTH) + 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL midrst_done got=%0d pulses exp=0", seen); end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    check_op("after_reset_add", 32'd5, 32'd7, F_ADD);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
